uart_tx_sched: RTL

//   Round-robin scheduler sharing one UART transmitter between four byte producers.
//   - Each requester offers a byte; the block arbitrates and drives the UART's

---
 rtl/uart_tx_sched_if.sv | 32 +++
 rtl/uart_tx_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched_if
// Description : Producer-side and UART-side signal bundle for the
//               four-requester UART transmit scheduler. The scheduler takes
//               the slave view; the producers plus the UART take the master
//               view.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_sched_if;
    logic [3:0]  req;          // byte pending per requester
    logic [3:0]  lock;         // keep grant for the next byte
    logic [31:0] data_in;      // byte i on data_in[8*i+7:8*i]
    logic [3:0]  ack;          // byte of requester i captured
    logic [3:0]  grant;        // one-hot owner, 0 when idle
    logic        transmit;     // start request to UART TX
    logic [7:0]  data_tx;      // byte presented to UART TX
    logic        tx_busy;      // UART TX shifting a frame
    logic        timeout_err;  // UART never went busy
    logic        idle;         // scheduler in IDLE

    modport master (
        output req, lock, data_in, tx_busy,
        input  ack, grant, transmit, data_tx, timeout_err, idle
    );

    modport slave (
        input  req, lock, data_in, tx_busy,
        output ack, grant, transmit, data_tx, timeout_err, idle
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler sharing one UART transmitter between
//               four byte producers, with optional grant locking so a
//               multi-byte packet from one producer stays contiguous.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
    parameter logic [7:0] TIMEOUT = 8'd64,  // cycles transmit may wait for tx_busy
    parameter logic [8:0] GAP     = 9'd0    // idle cycles after tx_busy falls
) (
    input  logic           clk,
    input  logic           nRst,
    uart_tx_sched_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SEND  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    logic [1:0] r_state,       w_state_nxt;
    logic [1:0] r_ptr,         w_ptr_nxt;
    logic [1:0] r_owner,       w_owner_nxt;
    logic       r_lock_held,   w_lock_held_nxt;
    logic [7:0] r_cnt,         w_cnt_nxt;
    logic [8:0] r_gap_cnt,     w_gap_cnt_nxt;
    logic [3:0] r_ack,         w_ack_nxt;
    logic [3:0] r_grant,       w_grant_nxt;
    logic       r_transmit,    w_transmit_nxt;
    logic [7:0] r_data_tx,     w_data_tx_nxt;
    logic       r_timeout_err, w_timeout_err_nxt;

    logic [1:0] w_scan;
    logic [1:0] w_rr_idx;
    logic       w_rr_found;
    logic       w_lock_hit;
    logic       w_win_valid;
    logic [1:0] w_win;
    logic [3:0] w_win_onehot;
    logic [1:0] w_owner_inc;
    logic       w_done;

    // Round-robin search: first pending request at ptr, ptr+1, ... mod 4
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_ptr;
        w_scan     = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_scan = r_ptr + k[1:0];
            if (!w_rr_found && bus.req[w_scan]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan;
            end
        end
    end

    // A locked owner that still requests beats the round-robin choice
    assign w_lock_hit   = r_lock_held & bus.req[r_owner];
    assign w_win_valid  = w_lock_hit | w_rr_found;
    assign w_win        = w_lock_hit ? r_owner : w_rr_idx;
    assign w_win_onehot = 4'b0001 << w_win;
    assign w_owner_inc  = r_owner + 2'd1;

    // Next-state and registered-output computation
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_owner_nxt       = r_owner;
        w_lock_held_nxt   = r_lock_held;
        w_cnt_nxt         = r_cnt;
        w_gap_cnt_nxt     = r_gap_cnt;
        w_ack_nxt         = 4'b0000;
        w_grant_nxt       = r_grant;
        w_transmit_nxt    = r_transmit;
        w_data_tx_nxt     = r_data_tx;
        w_timeout_err_nxt = 1'b0;
        w_done            = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // Owner went quiet: drop the lock, plain round-robin applies
                if (!w_lock_hit) begin
                    w_lock_held_nxt = 1'b0;
                end
                if (w_win_valid) begin
                    w_state_nxt     = c_ST_SEND;
                    w_transmit_nxt  = 1'b1;
                    w_data_tx_nxt   = bus.data_in[{w_win, 3'b000} +: 8];
                    w_ack_nxt       = w_win_onehot;
                    w_grant_nxt     = w_win_onehot;
                    w_owner_nxt     = w_win;
                    w_lock_held_nxt = bus.lock[w_win];
                    w_cnt_nxt       = 8'd0;
                end
            end

            c_ST_SEND: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (bus.tx_busy) begin
                    w_transmit_nxt = 1'b0;
                    w_state_nxt    = c_ST_DRAIN;
                end else if (r_cnt == TIMEOUT - 8'd1) begin
                    // UART never picked the byte up: abort and move past owner
                    w_transmit_nxt    = 1'b0;
                    w_timeout_err_nxt = 1'b1;
                    w_grant_nxt       = 4'b0000;
                    w_lock_held_nxt   = 1'b0;
                    w_ptr_nxt         = w_owner_inc;
                    w_state_nxt       = c_ST_IDLE;
                end
            end

            c_ST_DRAIN: begin
                if (!bus.tx_busy) begin
                    if (GAP == 9'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt   = c_ST_GAP;
                        w_gap_cnt_nxt = 9'd0;
                    end
                end
            end

            c_ST_GAP: begin
                w_gap_cnt_nxt = r_gap_cnt + 9'd1;
                if (r_gap_cnt == GAP - 9'd1) begin
                    w_done = 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // Frame finished: release grant; a held lock keeps ptr where it is
        if (w_done) begin
            w_state_nxt = c_ST_IDLE;
            w_grant_nxt = 4'b0000;
            if (!r_lock_held) begin
                w_ptr_nxt = w_owner_inc;
            end
        end
    end

    // State and output registers, cleared immediately by nRst
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state       <= c_ST_IDLE;
            r_ptr         <= 2'd0;
            r_owner       <= 2'd0;
            r_lock_held   <= 1'b0;
            r_cnt         <= 8'd0;
            r_gap_cnt     <= 9'd0;
            r_ack         <= 4'b0000;
            r_grant       <= 4'b0000;
            r_transmit    <= 1'b0;
            r_data_tx     <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_owner       <= w_owner_nxt;
            r_lock_held   <= w_lock_held_nxt;
            r_cnt         <= w_cnt_nxt;
            r_gap_cnt     <= w_gap_cnt_nxt;
            r_ack         <= w_ack_nxt;
            r_grant       <= w_grant_nxt;
            r_transmit    <= w_transmit_nxt;
            r_data_tx     <= w_data_tx_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign bus.ack         = r_ack;
    assign bus.grant       = r_grant;
    assign bus.transmit    = r_transmit;
    assign bus.data_tx     = r_data_tx;
    assign bus.timeout_err = r_timeout_err;
    assign bus.idle        = (r_state == c_ST_IDLE);

endmodule
`default_nettype wire
